// File: rtl/microcode_sequencer_if.sv
// Bus between the microcode sequencer and its surroundings: instruction
// fields, flags, memory handshake, microcode ROM port and status outputs.
interface microcode_sequencer_if #(
   parameter int OPCODE_WIDTH = 4,
   parameter int MSTEP_WIDTH  = 3,
   parameter int CW_WIDTH     = 27,
   parameter int COUNT_WIDTH  = 16
);
   logic [OPCODE_WIDTH-1:0]             opcode;
   logic                                flag_zero;
   logic                                flag_carry;
   logic                                flag_negative;
   logic                                mem_ready;
   logic                                step_mode;
   logic                                resume;
   logic [CW_WIDTH-1:0]                 ucode_word;
   logic [OPCODE_WIDTH+MSTEP_WIDTH-1:0] ucode_addr;
   logic [CW_WIDTH-1:0]                 control_word;
   logic [2:0]                          state;
   logic [MSTEP_WIDTH-1:0]              microstep;
   logic                                halted;
   logic                                fault;
   logic                                retired;
   logic [COUNT_WIDTH-1:0]              retire_count;

   // Sequencer side
   modport master (
      input  opcode, flag_zero, flag_carry, flag_negative, mem_ready,
             step_mode, resume, ucode_word,
      output ucode_addr, control_word, state, microstep, halted, fault,
             retired, retire_count
   );

   // Datapath / ROM / debug side
   modport slave (
      output opcode, flag_zero, flag_carry, flag_negative, mem_ready,
             step_mode, resume, ucode_word,
      input  ucode_addr, control_word, state, microstep, halted, fault,
             retired, retire_count
   );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetch / decode / execute control FSM that walks a
// per-opcode microprogram, gates conditional PC loads on the flags, counts
// retired instructions and halts on HALT, single-step or microstep overflow.
module microcode_sequencer #(
   parameter int OPCODE_WIDTH = 4,
   parameter int MSTEP_WIDTH  = 3,
   parameter int CW_WIDTH     = 27,
   parameter int HALT_BIT     = 26,
   parameter int LAST_BIT     = 25,
   parameter int LOAD_PC_BIT  = 23,
   parameter int CHK_Z_BIT    = 10,
   parameter int CHK_C_BIT    = 9,
   parameter int CHK_N_BIT    = 8,
   parameter logic [CW_WIDTH-1:0] FETCH0_CW  = '0,
   parameter logic [CW_WIDTH-1:0] FETCH1_CW  = '0,
   parameter logic [CW_WIDTH-1:0] DECODE0_CW = '0,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   microcode_sequencer_if.master bus
);
   localparam int MAX_STEPS = 2 ** MSTEP_WIDTH;

   typedef enum logic [2:0] {
      S_RESET    = 3'd0,
      S_FETCH_0  = 3'd1,
      S_FETCH_1  = 3'd2,
      S_DECODE_0 = 3'd3,
      S_DECODE_1 = 3'd4,
      S_EXECUTE  = 3'd5,
      S_WAIT     = 3'd6,
      S_HALT     = 3'd7
   } state_t;

   state_t                  state_reg, state_next;
   logic [MSTEP_WIDTH-1:0]  microstep_reg;
   logic [OPCODE_WIDTH-1:0] opcode_q_reg;
   logic                    fault_reg;
   logic [COUNT_WIDTH-1:0]  retire_count_reg;

   logic                    halt_bit, last_bit, at_max_step;
   logic                    chk_any, chk_pass;
   logic [CW_WIDTH-1:0]     cw_exec;

   assign halt_bit    = bus.ucode_word[HALT_BIT];
   assign last_bit    = bus.ucode_word[LAST_BIT];
   assign at_max_step = (microstep_reg == MSTEP_WIDTH'(MAX_STEPS - 1));

   // Conditional PC load: when any flag check is requested, the load survives
   // only if at least one of the checked flags is set.
   always_comb begin
      chk_any  = bus.ucode_word[CHK_Z_BIT] | bus.ucode_word[CHK_C_BIT] |
                 bus.ucode_word[CHK_N_BIT];
      chk_pass = (bus.ucode_word[CHK_Z_BIT] & bus.flag_zero)  |
                 (bus.ucode_word[CHK_C_BIT] & bus.flag_carry) |
                 (bus.ucode_word[CHK_N_BIT] & bus.flag_negative);
      cw_exec  = bus.ucode_word;
      if (chk_any && !chk_pass)
         cw_exec[LOAD_PC_BIT] = 1'b0;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= S_RESET;
      else
         state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_RESET:    state_next = S_FETCH_0;
         S_FETCH_0:  state_next = S_FETCH_1;
         S_FETCH_1:  state_next = bus.mem_ready ? S_DECODE_0 : S_WAIT;
         S_WAIT:     state_next = bus.mem_ready ? S_DECODE_0 : S_WAIT;
         S_DECODE_0: state_next = S_DECODE_1;
         S_DECODE_1: state_next = S_EXECUTE;
         S_EXECUTE: begin
            if (halt_bit)
               state_next = S_HALT;
            else if (last_bit)
               state_next = bus.step_mode ? S_HALT : S_FETCH_0;
            else if (at_max_step)
               state_next = S_HALT;
         end
         S_HALT:     state_next = bus.resume ? S_FETCH_0 : S_HALT;
         default:    state_next = S_RESET;
      endcase
   end

   // Moore/Mealy outputs: per-state control word, halt and retire strobes
   always_comb begin
      bus.control_word = '0;
      bus.halted       = 1'b0;
      bus.retired      = 1'b0;
      case (state_reg)
         S_FETCH_0:  bus.control_word = FETCH0_CW;
         S_FETCH_1:  bus.control_word = FETCH1_CW;
         S_DECODE_0: bus.control_word = DECODE0_CW;
         S_EXECUTE: begin
            bus.control_word = cw_exec;
            bus.retired      = last_bit & ~halt_bit;
         end
         S_HALT:     bus.halted = 1'b1;
         default:    bus.control_word = '0;
      endcase
   end

   // Datapath registers: latched opcode, microstep, sticky fault, retire count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         microstep_reg    <= '0;
         opcode_q_reg     <= '0;
         fault_reg        <= 1'b0;
         retire_count_reg <= '0;
      end else begin
         case (state_reg)
            S_DECODE_1: begin
               opcode_q_reg  <= bus.opcode;
               microstep_reg <= '0;
            end
            S_EXECUTE: begin
               if (!halt_bit) begin
                  if (last_bit) begin
                     retire_count_reg <= retire_count_reg + 1'b1;
                     microstep_reg    <= '0;
                  end else begin
                     microstep_reg <= microstep_reg + 1'b1;
                     if (at_max_step)
                        fault_reg <= 1'b1;
                  end
               end
            end
            S_HALT: begin
               if (bus.resume)
                  fault_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.state        = state_reg;
   assign bus.microstep    = microstep_reg;
   assign bus.fault        = fault_reg;
   assign bus.retire_count = retire_count_reg;
   assign bus.ucode_addr   = {opcode_q_reg, microstep_reg};
endmodule
